uart_pkt_rx: RTL
================

UART_PKT_RX -- requirements
Module: uart_pkt_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS, integer-truncated.
REQ-003 Parameter FRAME_LEN, default 14, total bytes per frame including head and tail; legal range 4..32.
REQ-004 Parameter HEAD_BYTE, default 8'h55, first byte of every frame.
REQ-005 Parameter TAIL_BYTE, default 8'hAA, last byte of every frame.
REQ-006 Parameter CHK_EN, default 1; when 1, byte FRAME_LEN-2 is a checksum.
REQ-007 Parameter GAP_BITS, default 20, inter-byte timeout in bit times.
REQ-008 sys_clk  in  1  single clock; all logic on its rising edge.
REQ-009 sys_rst_n  in  1  asynchronous active-low reset.
REQ-010 uart_rxd  in  1  serial line, idle high, 8N1, LSB first, asynchronous to sys_clk.
REQ-011 byte_data  out  8  last received byte, valid with byte_valid.
REQ-012 byte_valid  out  1  one-cycle pulse per correctly framed byte.
REQ-013 busy  out  1  high while a frame is being collected.
REQ-014 frame_valid  out  1  one-cycle pulse on each accepted frame.
REQ-015 frame_err  out  1  one-cycle pulse on each rejected frame.
REQ-016 err_code  out  2  0 stop-bit error, 1 tail mismatch, 2 checksum mismatch, 3 timeout; held until the next frame_err.
REQ-017 payload  out  (FRAME_LEN-2)*8  bytes 1..FRAME_LEN-2 of the last accepted frame; byte 1 in the MSBs.

Function
REQ-018 uart_rxd shall pass through a 2-FF synchroniser; start shall be detected on a falling edge of the synchronised line while the bit engine is idle.
REQ-019 The bit engine shall sample at clock count BPS_CNT/2 of each bit; a start bit sampled high shall abort reception with no output (false start).
REQ-020 Data bits 0..7 shall be sampled at the mid-points of bit periods 1..8; the stop bit shall be sampled at the mid-point of bit period 9.
REQ-021 The engine shall return to idle at stop-bit mid-point, allowing a back-to-back start edge in the second half of the stop bit.
REQ-022 A stop bit sampled high shall pulse byte_valid with byte_data for one cycle; a stop bit sampled low shall produce no byte_valid and shall raise an internal stop_err pulse.
REQ-023 The frame FSM states shall be F_IDLE and F_RECV; busy = (state == F_RECV).
REQ-024 In F_IDLE, a byte equal to HEAD_BYTE shall store index 0 and move the FSM to F_RECV; any other byte, and any stop_err, shall be discarded silently.
REQ-025 In F_RECV, each byte shall be stored at the next index; on index FRAME_LEN-1 the frame is complete and the FSM returns to F_IDLE.
REQ-026 On completion, the tail byte shall be checked against TAIL_BYTE; if CHK_EN, byte FRAME_LEN-2 shall be checked against the mod-256 sum of bytes 1..FRAME_LEN-3.
REQ-027 Tail error shall take priority over checksum error.
REQ-028 frame_valid or frame_err shall pulse in the cycle after the final byte_valid, i.e. 1-cycle latency.
REQ-029 payload shall update in the same cycle as frame_valid and shall hold on error.
REQ-030 stop_err in F_RECV shall pulse frame_err with err_code 0 and return the FSM to F_IDLE.
REQ-031 In F_RECV, a gap counter shall clear on each byte_valid; reaching GAP_BITS*BPS_CNT clocks shall pulse frame_err with err_code 3 and return the FSM to F_IDLE.
REQ-032 If byte_valid and the gap terminal count occur in the same cycle, the byte shall win and no timeout shall occur.
REQ-033 frame_valid and frame_err shall never be high in the same cycle.

Reset
REQ-034 Asserting sys_rst_n low shall immediately clear the synchroniser (to 1), the bit engine, the FSM (to F_IDLE), the byte index and the gap counter.
REQ-035 During reset, byte_data, byte_valid, busy, frame_valid, frame_err, err_code and payload shall all be 0.
REQ-036 A partially received frame shall be discarded on reset; after release, reception shall resume only from the next falling edge.

Verification (FRAME_LEN=6, CHK_EN=1, defaults otherwise)
REQ-037 Send 55 01 12 34 47 AA -> frame_valid pulses once; payload = 32'h01123447; err_code unchanged.
REQ-038 Send 55 01 12 34 00 AA -> frame_err with err_code 2; payload retains its previous value.
REQ-039 Send 55 01 12 34 47 BB -> frame_err with err_code 1.
REQ-040 Send 55 01, then idle for 20 bit times -> frame_err with err_code 3 and busy low; a following 55 01 12 34 47 AA -> frame_valid.
REQ-041 Send 00 FF, a 55 with stop bit forced low, then 55 01 12 34 47 AA -> no frame_err, a single frame_valid, and 8 byte_valid pulses.
REQ-042 Assert reset after 55 01 12, release it, then send the full good frame -> exactly one frame_valid and no frame_err.

Source files
------------

// File: rtl/uart_pkt_rx.sv
// UART 8N1 byte receiver feeding a framed-packet collector with head/tail,
// optional additive checksum and an inter-byte timeout.
module uart_pkt_rx #(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         UART_BPS  = 115200,
    parameter int         FRAME_LEN = 14,
    parameter logic [7:0] HEAD_BYTE = 8'h55,
    parameter logic [7:0] TAIL_BYTE = 8'hAA,
    parameter int         CHK_EN    = 1,
    parameter int         GAP_BITS  = 20
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       uart_rxd,
    output logic [7:0]                 byte_data,
    output logic                       byte_valid,
    output logic                       busy,
    output logic                       frame_valid,
    output logic                       frame_err,
    output logic [1:0]                 err_code,
    output logic [(FRAME_LEN-2)*8-1:0] payload
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT + 1);
    localparam int GAP_TC  = GAP_BITS * BPS_CNT;
    localparam int GAP_W   = $clog2(GAP_TC + 1);
    localparam int PW      = (FRAME_LEN - 2) * 8;
    localparam int IDX_W   = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(BPS_CNT / 2);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TC - 1);
    localparam logic [IDX_W-1:0] IDX_PRE  = IDX_W'(FRAME_LEN - 2);
    localparam logic [IDX_W-1:0] IDX_SUM  = IDX_W'(FRAME_LEN - 3);

    // ---------------- bit engine ----------------
    logic             rx_s1, rx_s2, rx_d;
    logic             rx_run;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;
    logic             stop_err;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            rx_run     <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            rx_s1      <= uart_rxd;
            rx_s2      <= rx_s1;
            rx_d       <= rx_s2;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            if (!rx_run) begin
                if (rx_d && !rx_s2) begin
                    rx_run  <= 1'b1;
                    bit_cnt <= '0;
                    bit_idx <= '0;
                end
            end else begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt <= '0;
                    bit_idx <= bit_idx + 4'd1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (bit_cnt == BIT_HALF) begin
                    if (bit_idx == 4'd0) begin
                        if (rx_s2) rx_run <= 1'b0;   // glitch, not a real start bit
                    end else if (bit_idx <= 4'd8) begin
                        shreg <= {rx_s2, shreg[7:1]};
                    end else begin
                        // Leave at stop mid-point so a back-to-back start edge is caught.
                        rx_run <= 1'b0;
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            stop_err <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- frame FSM ----------------
    typedef enum logic {F_IDLE, F_RECV} fstate_t;

    fstate_t          state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [7:0]       sum;
    logic [PW-1:0]    pay_buf;
    logic [GAP_W-1:0] gap_cnt;
    logic             fv_nx, fe_nx;
    logic [1:0]       ec_nx;
    logic             tail_bad, chk_bad;

    assign busy = (state == F_RECV);

    always_comb begin
        state_nx = state;
        fv_nx    = 1'b0;
        fe_nx    = 1'b0;
        ec_nx    = err_code;
        tail_bad = (byte_data != TAIL_BYTE);
        chk_bad  = (CHK_EN != 0) && (pay_buf[7:0] != sum);
        case (state)
            F_IDLE: begin
                if (byte_valid && byte_data == HEAD_BYTE) state_nx = F_RECV;
            end
            F_RECV: begin
                if (stop_err) begin
                    state_nx = F_IDLE;
                    fe_nx    = 1'b1;
                    ec_nx    = 2'd0;
                end else if (byte_valid) begin
                    // A byte arriving on the terminal gap count wins over the timeout.
                    if (idx == IDX_PRE) begin
                        state_nx = F_IDLE;
                        if (tail_bad) begin
                            fe_nx = 1'b1;
                            ec_nx = 2'd1;
                        end else if (chk_bad) begin
                            fe_nx = 1'b1;
                            ec_nx = 2'd2;
                        end else begin
                            fv_nx = 1'b1;
                        end
                    end
                end else if (gap_cnt == GAP_LAST) begin
                    state_nx = F_IDLE;
                    fe_nx    = 1'b1;
                    ec_nx    = 2'd3;
                end
            end
            default: state_nx = F_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= F_IDLE;
            idx         <= '0;
            sum         <= '0;
            pay_buf     <= '0;
            gap_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
            payload     <= '0;
        end else begin
            state       <= state_nx;
            frame_valid <= fv_nx;
            frame_err   <= fe_nx;
            err_code    <= ec_nx;
            if (fv_nx) payload <= pay_buf;
            if (state == F_IDLE) begin
                idx     <= '0;
                sum     <= '0;
                gap_cnt <= '0;
            end else if (byte_valid) begin
                idx     <= idx + 1'b1;
                gap_cnt <= '0;
                // The tail is checked directly from byte_data and never buffered.
                if (idx != IDX_PRE) pay_buf <= {pay_buf[PW-9:0], byte_data};
                if (idx < IDX_SUM) sum <= sum + byte_data;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule
